// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-side controller for the pipelined CPU.
//
// Gates the PC register write enable, selects the next PC, sequences boot
// after start_i, holds fetch while instruction memory is not ready or a
// load-use hazard is flagged, and captures taken branches that arrive
// during a memory wait so they can be applied on the next ready cycle.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            run enable (level)
//   pc_i               current PC from the PC register
//   hazard_stall_i     load-use stall from hazard detection
//   branch_taken_i     branch/jump resolved taken in ID
//   branch_target_i    redirect address, valid with branch_taken_i
//   imem_ready_i       instruction memory delivers the fetch this cycle
//   imem_req_o         fetch request
//   pc_write_o         PC register write enable
//   next_pc_o          PC register data input
//   ifid_write_o       IF/ID register write enable
//   ifid_flush_o       IF/ID register flush (bubble)
//   stall_cnt_o        saturating count of lost fetch cycles
//   state_o            FSM state (IDLE=0, BOOT=1, RUN=2, WAIT_MEM=3)

module pc_sequencer #(
   parameter int unsigned BOOT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        hazard_stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        imem_ready_i,
   output logic        imem_req_o,
   output logic        pc_write_o,
   output logic [31:0] next_pc_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic [15:0] stall_cnt_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BOOT     = 2'd1,
      RUN      = 2'd2,
      WAIT_MEM = 2'd3
   } state_t;

   localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  boot_cnt;
   logic        pend_v;
   logic [31:0] pend_pc;
   logic [15:0] stall_cnt;

   logic        advance;
   logic        branch_ok;
   logic        redirect;
   logic        latch;
   logic        lost;

   // A hazard masks the branch entirely: it is neither applied nor latched,
   // and ID presents it again once the stall drops.
   assign advance   = imem_ready_i & ~hazard_stall_i;
   assign branch_ok = branch_taken_i & ~hazard_stall_i;

   // Next-state and Mealy outputs.
   always_comb begin
      state_nxt    = state;
      imem_req_o   = 1'b0;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b0;
      next_pc_o    = pc_i + 32'd4;
      redirect     = 1'b0;
      latch        = 1'b0;
      lost         = 1'b0;

      case (state)
         IDLE: begin
            if (start_i) state_nxt = BOOT;
         end
         BOOT: begin
            if (boot_cnt == 4'd0) state_nxt = RUN;
         end
         RUN, WAIT_MEM: begin
            // A pending redirect outranks a fresh branch, which is dropped.
            if (pend_v)         next_pc_o = pend_pc;
            else if (branch_ok) next_pc_o = branch_target_i;

            if (start_i) begin
               imem_req_o   = 1'b1;
               pc_write_o   = advance;
               ifid_write_o = advance;
               redirect     = advance & (pend_v | branch_ok);
               // Branch seen while memory is busy: park the target and
               // bubble the stale IF/ID entry now.
               latch        = branch_ok & ~imem_ready_i & ~pend_v;
               ifid_flush_o = redirect | latch;
               lost         = ~advance;
            end

            state_nxt = imem_ready_i ? RUN : WAIT_MEM;
         end
         default: state_nxt = IDLE;
      endcase

      if (!start_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         boot_cnt  <= 4'd0;
         pend_v    <= 1'b0;
         pend_pc   <= 32'd0;
         stall_cnt <= 16'd0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && start_i)
            boot_cnt <= BOOT_LOAD;
         else if (state == BOOT && boot_cnt != 4'd0)
            boot_cnt <= boot_cnt - 4'd1;

         if (!start_i || redirect) begin
            pend_v <= 1'b0;
         end else if (latch) begin
            pend_v  <= 1'b1;
            pend_pc <= branch_target_i;
         end

         // Dropping start_i zeroes lost, so the count holds while idle.
         if (lost && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign state_o     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table for boot,
// streaming, hazard, branch and memory-wait behaviour, followed by
// hand-written sequences for PC wrap, start drop, reset and counter
// saturation. The bench plays the PC register.

module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        hazard;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ready;
   logic        imem_req;
   logic        pc_write;
   logic [31:0] next_pc;
   logic        ifid_write;
   logic        ifid_flush;
   logic [15:0] stall_cnt;
   logic [1:0]  state;

   logic [31:0] pc_q;
   logic        pc_load;
   logic [31:0] pc_load_val;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.BOOT_CYCLES(2)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .pc_i            (pc_q),
      .hazard_stall_i  (hazard),
      .branch_taken_i  (br_taken),
      .branch_target_i (br_target),
      .imem_ready_i    (ready),
      .imem_req_o      (imem_req),
      .pc_write_o      (pc_write),
      .next_pc_o       (next_pc),
      .ifid_write_o    (ifid_write),
      .ifid_flush_o    (ifid_flush),
      .stall_cnt_o     (stall_cnt),
      .state_o         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register stand-in, with a bench-side load port for forcing values.
   always @(posedge clk) begin
      if (rst)           pc_q <= 32'd0;
      else if (pc_load)  pc_q <= pc_load_val;
      else if (pc_write) pc_q <= next_pc;
   end

   typedef struct {
      logic        st;
      logic        hz;
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      logic        e_req;
      logic        e_pcw;
      logic        e_fl;
      logic [31:0] e_npc;
      logic [1:0]  e_state;   // after the edge
      logic [15:0] e_cnt;     // after the edge
   } vec_t;

   localparam int NV = 24;
   vec_t vec [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic hz, input logic br,
                        input logic [31:0] tgt, input logic rdy);
      start = st; hazard = hz; br_taken = br; br_target = tgt; ready = rdy;
   endtask

   // Inputs change at posedge+1, comb outputs sampled at posedge+2,
   // registered outputs sampled at posedge+1 of the following edge.
   task automatic edge_wait();
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input int i);
      string tag;
      drive(vec[i].st, vec[i].hz, vec[i].br, vec[i].tgt, vec[i].rdy);
      #1;
      tag = $sformatf("v%0d", i);
      chk({tag, ".imem_req"},   32'(imem_req),   32'(vec[i].e_req));
      chk({tag, ".pc_write"},   32'(pc_write),   32'(vec[i].e_pcw));
      chk({tag, ".ifid_write"}, 32'(ifid_write), 32'(vec[i].e_pcw));
      chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(vec[i].e_fl));
      chk({tag, ".next_pc"},    next_pc,         vec[i].e_npc);
      edge_wait();
      chk({tag, ".state"},      32'(state),      32'(vec[i].e_state));
      chk({tag, ".stall_cnt"},  32'(stall_cnt),  32'(vec[i].e_cnt));
   endtask

   initial begin
      //           st hz br tgt        rdy  req pcw fl npc        state cnt
      vec[0]  = '{1, 0, 0, 32'h0,     1,   0,  0,  0, 32'h4,    2'd1, 16'd0};
      vec[1]  = '{1, 0, 0, 32'h0,     1,   0,  0,  0, 32'h4,    2'd1, 16'd0};
      vec[2]  = '{1, 0, 0, 32'h0,     1,   0,  0,  0, 32'h4,    2'd2, 16'd0};
      vec[3]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h4,    2'd2, 16'd0};
      vec[4]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h8,    2'd2, 16'd0};
      vec[5]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'hC,    2'd2, 16'd0};
      vec[6]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h10,   2'd2, 16'd0};
      vec[7]  = '{1, 1, 0, 32'h0,     1,   1,  0,  0, 32'h14,   2'd2, 16'd1};
      vec[8]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h14,   2'd2, 16'd1};
      vec[9]  = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h18,   2'd2, 16'd1};
      vec[10] = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h1C,   2'd2, 16'd1};
      vec[11] = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h20,   2'd2, 16'd1};
      vec[12] = '{1, 0, 1, 32'h40,    1,   1,  1,  1, 32'h40,   2'd2, 16'd1};
      vec[13] = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h44,   2'd2, 16'd1};
      vec[14] = '{1, 0, 1, 32'h80,    0,   1,  0,  1, 32'h80,   2'd3, 16'd2};
      vec[15] = '{1, 0, 0, 32'h0,     0,   1,  0,  0, 32'h80,   2'd3, 16'd3};
      vec[16] = '{1, 0, 0, 32'h0,     0,   1,  0,  0, 32'h80,   2'd3, 16'd4};
      vec[17] = '{1, 0, 0, 32'h0,     1,   1,  1,  1, 32'h80,   2'd2, 16'd4};
      vec[18] = '{1, 1, 1, 32'h200,   1,   1,  0,  0, 32'h84,   2'd2, 16'd5};
      vec[19] = '{1, 0, 0, 32'h0,     0,   1,  0,  0, 32'h84,   2'd3, 16'd6};
      vec[20] = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h84,   2'd2, 16'd6};
      vec[21] = '{1, 0, 1, 32'h100,   0,   1,  0,  1, 32'h100,  2'd3, 16'd7};
      vec[22] = '{1, 0, 1, 32'h300,   1,   1,  1,  1, 32'h100,  2'd2, 16'd7};
      vec[23] = '{1, 0, 0, 32'h0,     1,   1,  1,  0, 32'h104,  2'd2, 16'd7};

      rst = 1'b1; pc_load = 1'b0; pc_load_val = 32'd0;
      drive(0, 0, 0, 32'd0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst.state",      32'(state),      32'd0);
      chk("rst.stall_cnt",  32'(stall_cnt),  32'd0);
      chk("rst.imem_req",   32'(imem_req),   32'd0);
      chk("rst.pc_write",   32'(pc_write),   32'd0);
      chk("rst.ifid_write", 32'(ifid_write), 32'd0);
      chk("rst.ifid_flush", 32'(ifid_flush), 32'd0);
      chk("rst.next_pc",    next_pc,         32'h4);
      edge_wait();

      for (int i = 0; i < NV; i++) run_vec(i);

      // PC wrap: force 0xFFFFFFFC during a hazard cycle (count 7 -> 8).
      drive(1, 1, 0, 32'd0, 1);
      pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
      edge_wait();
      pc_load = 1'b0;
      drive(1, 0, 0, 32'd0, 1);
      #1;
      chk("wrap.next_pc",  next_pc,         32'h0);
      chk("wrap.pc_write", 32'(pc_write),   32'd1);
      edge_wait();
      chk("wrap.pc_after", pc_q,            32'h0);
      chk("wrap.next_pc2", next_pc,         32'h4);
      chk("wrap.stall_cnt", 32'(stall_cnt), 32'd8);

      // Start drop mid-WAIT_MEM with a pending redirect.
      drive(1, 0, 1, 32'h500, 0);
      #1;
      chk("drop.latch_flush", 32'(ifid_flush), 32'd1);
      edge_wait();
      chk("drop.state_wait", 32'(state), 32'd3);
      drive(0, 0, 0, 32'd0, 0);
      #1;
      chk("drop.imem_req",   32'(imem_req),   32'd0);
      chk("drop.pc_write",   32'(pc_write),   32'd0);
      chk("drop.ifid_flush", 32'(ifid_flush), 32'd0);
      edge_wait();
      chk("drop.state_idle", 32'(state),     32'd0);
      chk("drop.stall_hold", 32'(stall_cnt), 32'd9);
      pc_load = 1'b1; pc_load_val = 32'h1000;
      edge_wait();
      pc_load = 1'b0;
      drive(1, 0, 0, 32'd0, 1);
      repeat (3) edge_wait();
      chk("restart.state",   32'(state),      32'd2);
      chk("restart.no_pend", next_pc,         32'h1004);
      chk("restart.flush",   32'(ifid_flush), 32'd0);
      edge_wait();

      // Reset mid-WAIT_MEM discards the pending redirect.
      drive(1, 0, 1, 32'h600, 0);
      edge_wait();
      chk("rstw.state_wait", 32'(state), 32'd3);
      drive(1, 0, 0, 32'd0, 1);
      rst = 1'b1;
      edge_wait();
      rst = 1'b0;
      chk("rstw.state",     32'(state),     32'd0);
      chk("rstw.stall_cnt", 32'(stall_cnt), 32'd0);
      #1;
      chk("rstw.imem_req",  32'(imem_req),  32'd0);
      repeat (3) edge_wait();
      chk("rstw.run",       32'(state),      32'd2);
      chk("rstw.no_pend",   next_pc,         32'h4);
      chk("rstw.flush",     32'(ifid_flush), 32'd0);

      // Saturation: 70000 hazard cycles, then reset clears the count.
      drive(1, 1, 0, 32'd0, 1);
      repeat (70000) @(posedge clk);
      #1;
      chk("sat.stall_cnt", 32'(stall_cnt), 32'hFFFF);
      chk("sat.state",     32'(state),     32'd2);
      rst = 1'b1;
      edge_wait();
      rst = 1'b0;
      drive(0, 0, 0, 32'd0, 0);
      chk("sat.rst_cnt",   32'(stall_cnt), 32'd0);
      chk("sat.rst_state", 32'(state),     32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the pipelined CPU. It gates the PC register's write enable and selects the next PC. It also sequences boot after `start_i`, and holds fetch while instruction memory is not ready or a load-use hazard is flagged. It captures taken branches that arrive during a memory wait and applies them later. Outputs drive the PC register's `PCWrite_i` and `pc_i`, plus the IF/ID register's write and flush controls.

## Interface
- `BOOT_CYCLES`, default 2: idle cycles between `start_i` rising and the first fetch request. Legal range is 1..15.
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: run enable, level-sensitive.
- `pc_i` in 32: current PC, from the PC register output.
- `hazard_stall_i` in 1: load-use stall from hazard detection.
- `branch_taken_i` in 1: branch or jump resolved taken in ID.
- `branch_target_i` in 32: target address, valid when `branch_taken_i`=1.
- `imem_ready_i` in 1: instruction memory delivers the fetch this cycle.
- `imem_req_o` out 1: fetch request.
- `pc_write_o` out 1: connects to the PC register's `PCWrite_i`.
- `next_pc_o` out 32: connects to the PC register's `pc_i`.
- `ifid_write_o` out 1: IF/ID register write enable.
- `ifid_flush_o` out 1: IF/ID register flush (insert bubble).
- `stall_cnt_o` out 16: count of lost fetch cycles, saturating.
- `state_o` out 2: FSM state, for debug. IDLE=0, BOOT=1, RUN=2, WAIT_MEM=3.

## Operation
- **Registered state:** FSM state, 4-bit boot counter, pending-redirect flag `pend_v`, 32-bit `pend_pc`, 16-bit stall counter.
- **IDLE:**
  - All control outputs are 0.
  - `start_i`=1 → BOOT; the boot counter loads `BOOT_CYCLES`-1.
- **BOOT:**
  - All control outputs are 0.
  - The counter decrements each cycle. When it reaches 0 → RUN.
  - BOOT therefore lasts exactly `BOOT_CYCLES` cycles.
- **RUN and WAIT_MEM:**
  - `imem_req_o`=1 in both states.
  - `advance` = `imem_ready_i` & ~`hazard_stall_i`.
  - `pc_write_o` = `ifid_write_o` = `advance`.
- **Next PC selection**, in priority order:
  - `pend_v`=1 → `next_pc_o` = `pend_pc`.
  - else `branch_taken_i` & ~`hazard_stall_i` → `next_pc_o` = `branch_target_i`.
  - else `next_pc_o` = `pc_i` + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - In IDLE and BOOT, `next_pc_o` = `pc_i` + 4 and is unused.
- **Redirect applied:**
  - A redirect is applied when `advance`=1 and either `pend_v`=1 or `branch_taken_i` & ~`hazard_stall_i` is true.
  - In that cycle, `ifid_flush_o`=1 and `pend_v` clears.
  - When `pend_v`=1, a simultaneous `branch_taken_i` is ignored.
- **Branch during a memory wait:**
  - Condition: `branch_taken_i`=1, `hazard_stall_i`=0, `imem_ready_i`=0, `pend_v`=0.
  - Action: `pend_v`←1 and `pend_pc`←`branch_target_i`.
  - `ifid_flush_o`=1 in this cycle, so the stale IF/ID entry becomes a bubble.
- **Hazard priority:** `hazard_stall_i` overrides branch. While `hazard_stall_i`=1 the branch is neither applied nor latched; the branch is re-evaluated once the stall drops.
- **State transitions:**
  - RUN → WAIT_MEM when `imem_ready_i`=0.
  - WAIT_MEM → RUN when `imem_ready_i`=1.
  - A hazard alone does not change state.
- **Stall counter:**
  - Increments by 1 in each RUN/WAIT_MEM cycle where `pc_write_o`=0.
  - Holds at 0xFFFF.
  - Cleared only by reset.
- **Start dropped:** `start_i`=0 in any state has these effects:
  - Control outputs are forced to 0 in the same cycle.
  - The FSM goes to IDLE and `pend_v` clears.
  - The stall counter holds its value.

## Timing
- **Reset:** takes effect at the next rising edge with `rst_i`=1. After it, the block is in IDLE with:
  - `pend_v`=0, `pend_pc`=0, `stall_cnt_o`=0, boot counter 0.
  - Control outputs 0: `imem_req_o`, `pc_write_o`, `ifid_write_o`, `ifid_flush_o`.
  - `state_o`=0.
  - Reset overrides all other inputs. Asserting it mid-WAIT_MEM discards any pending redirect.
- **Output types:** control outputs and `next_pc_o` are combinational from registered state and current inputs (Mealy). `state_o` and `stall_cnt_o` are registered.
- **Startup:**
  - `start_i` sampled high at edge N → BOOT from N.
  - RUN from edge N+`BOOT_CYCLES`.
  - `imem_req_o` first high in the cycle after edge N+`BOOT_CYCLES`.
- **Latency:**
  - Redirect: applied in the same cycle when memory is ready; otherwise in the first ready cycle after the latch.
  - PC update: `pc_i` reflects `next_pc_o` one edge after `pc_write_o`=1.
  - Stall counter: updates one edge after the lost cycle.

## Test plan
- **Boot and streaming:** reset, `start_i`=1, `BOOT_CYCLES`=2, `pc_i` follows `next_pc_o`, ready tied 1 → `imem_req_o` rises 2 cycles after start; PC sequence 0,4,8,12; `stall_cnt_o`=0.
- **Load-use hazard:** `hazard_stall_i`=1 for 1 cycle at `pc_i`=0x10 → `pc_write_o`=0 and `ifid_write_o`=0 that cycle; `pc_i` stays 0x10 an extra cycle; `stall_cnt_o`=1.
- **Taken branch:** branch taken, target 0x40, at `pc_i`=0x20, ready=1 → `next_pc_o`=0x40, `ifid_flush_o`=1 for 1 cycle, next `pc_i`=0x40.
- **Branch during memory wait:** branch taken (target 0x80) while ready=0 for 3 cycles, `branch_taken_i` high only in the first → `ifid_flush_o` high in that first cycle; `pend_v` set; `state_o`=3; on the ready cycle `next_pc_o`=0x80 with flush; `stall_cnt_o`=3.
- **Branch under hazard, then PC wrap:** branch taken together with `hazard_stall_i`=1 → no redirect and no latch. At `pc_i`=0xFFFFFFFC → `next_pc_o`=0.
- **Start drop and reset:** drop `start_i` mid-WAIT_MEM with a pending redirect → outputs 0 immediately; IDLE next cycle; `pend_v`=0. Assert `rst_i` with 0xFFFF stalls accrued → `stall_cnt_o`=0 after the edge. Separately, 70000 forced stall cycles → counter holds at 0xFFFF.
